// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one registered-latency ALU between two requesters.
// Ports are tagged through the ALU pipeline so each result returns to its issuer.
module alu_arbiter #(
  parameter int unsigned ALU_LATENCY = 1,
  parameter logic [3:0]  IDLE_OP     = 4'hf
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid0,
  input  logic        req_valid1,
  output logic        req_ready0,
  output logic        req_ready1,
  input  logic [15:0] req_a0,
  input  logic [15:0] req_a1,
  input  logic [15:0] req_b0,
  input  logic [15:0] req_b1,
  input  logic [3:0]  req_op0,
  input  logic [3:0]  req_op1,
  output logic        rsp_valid0,
  output logic        rsp_valid1,
  input  logic        rsp_ready0,
  input  logic        rsp_ready1,
  output logic [15:0] rsp_out0,
  output logic [15:0] rsp_out1,
  output logic [4:0]  rsp_cond0,
  output logic [4:0]  rsp_cond1,
  output logic [15:0] alu_reg0,
  output logic [15:0] alu_reg1,
  output logic [3:0]  alu_op,
  input  logic [15:0] alu_out,
  input  logic [4:0]  alu_cond,
  output logic        busy
);

  logic [ALU_LATENCY-1:0] tag_valid;
  logic [ALU_LATENCY-1:0] tag_port;
  logic                   last_grant;
  logic [15:0]            hold_a;
  logic [15:0]            hold_b;

  logic inflight0, inflight1;
  logic elig0, elig1;
  logic grant0, grant1;
  logic accept;
  logic cap_valid, cap_port;

  // A port stays ineligible while its op is in the ALU or its result is unconsumed.
  assign inflight0 = |(tag_valid & ~tag_port);
  assign inflight1 = |(tag_valid & tag_port);
  assign elig0     = req_valid0 & ~inflight0 & ~rsp_valid0;
  assign elig1     = req_valid1 & ~inflight1 & ~rsp_valid1;

  assign grant0 = ~rst & elig0 & (~elig1 | last_grant);
  assign grant1 = ~rst & elig1 & (~elig0 | ~last_grant);
  assign accept = grant0 | grant1;

  assign req_ready0 = grant0;
  assign req_ready1 = grant1;

  always_comb begin
    alu_reg0 = hold_a;
    alu_reg1 = hold_b;
    alu_op   = IDLE_OP;
    if (grant0) begin
      alu_reg0 = req_a0;
      alu_reg1 = req_b0;
      alu_op   = req_op0;
    end else if (grant1) begin
      alu_reg0 = req_a1;
      alu_reg1 = req_b1;
      alu_op   = req_op1;
    end
  end

  assign cap_valid = tag_valid[ALU_LATENCY-1];
  assign cap_port  = tag_port[ALU_LATENCY-1];
  assign busy      = (|tag_valid) | rsp_valid0 | rsp_valid1;

  // Tag shift register, round-robin pointer, operand hold and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_valid  <= '0;
      tag_port   <= '0;
      last_grant <= 1'b1;
      hold_a     <= '0;
      hold_b     <= '0;
      rsp_valid0 <= 1'b0;
      rsp_valid1 <= 1'b0;
      rsp_out0   <= '0;
      rsp_out1   <= '0;
      rsp_cond0  <= '0;
      rsp_cond1  <= '0;
    end else begin
      tag_valid <= (tag_valid << 1) | ALU_LATENCY'(accept);
      tag_port  <= (tag_port << 1) | ALU_LATENCY'(grant1);
      if (accept) begin
        last_grant <= grant1;
        hold_a     <= alu_reg0;
        hold_b     <= alu_reg1;
      end
      if (rsp_valid0 && rsp_ready0) rsp_valid0 <= 1'b0;
      if (rsp_valid1 && rsp_ready1) rsp_valid1 <= 1'b0;
      // One-outstanding guarantees the target register is empty at capture.
      if (cap_valid && !cap_port) begin
        rsp_valid0 <= 1'b1;
        rsp_out0   <= alu_out;
        rsp_cond0  <= alu_cond;
      end
      if (cap_valid && cap_port) begin
        rsp_valid1 <= 1'b1;
        rsp_out1   <= alu_out;
        rsp_cond1  <= alu_cond;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter: latency 1 and latency 3 instances,
// each driving a small behavioural ALU.
module tb_alu_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // latency-1 instance signals
  logic        v0, v1, rdy0, rdy1, rv0, rv1, rr0, rr1, busy;
  logic [15:0] a0, a1, b0, b1, ro0, ro1, ar0, ar1, aout;
  logic [3:0]  op0, op1, aop;
  logic [4:0]  rc0, rc1, acond;

  // latency-3 instance signals
  logic        l_v0, l_v1, l_rdy0, l_rdy1, l_rv0, l_rv1, l_rr0, l_rr1, l_busy;
  logic [15:0] l_a0, l_a1, l_b0, l_b1, l_ro0, l_ro1, l_ar0, l_ar1, l_aout;
  logic [3:0]  l_op0, l_op1, l_aop;
  logic [4:0]  l_rc0, l_rc1, l_acond;

  alu_arbiter #(.ALU_LATENCY(1), .IDLE_OP(4'hf)) dut (
    .clk(clk), .rst(rst),
    .req_valid0(v0), .req_valid1(v1), .req_ready0(rdy0), .req_ready1(rdy1),
    .req_a0(a0), .req_a1(a1), .req_b0(b0), .req_b1(b1),
    .req_op0(op0), .req_op1(op1),
    .rsp_valid0(rv0), .rsp_valid1(rv1), .rsp_ready0(rr0), .rsp_ready1(rr1),
    .rsp_out0(ro0), .rsp_out1(ro1), .rsp_cond0(rc0), .rsp_cond1(rc1),
    .alu_reg0(ar0), .alu_reg1(ar1), .alu_op(aop),
    .alu_out(aout), .alu_cond(acond), .busy(busy)
  );

  alu_arbiter #(.ALU_LATENCY(3), .IDLE_OP(4'hf)) dut3 (
    .clk(clk), .rst(rst),
    .req_valid0(l_v0), .req_valid1(l_v1), .req_ready0(l_rdy0), .req_ready1(l_rdy1),
    .req_a0(l_a0), .req_a1(l_a1), .req_b0(l_b0), .req_b1(l_b1),
    .req_op0(l_op0), .req_op1(l_op1),
    .rsp_valid0(l_rv0), .rsp_valid1(l_rv1), .rsp_ready0(l_rr0), .rsp_ready1(l_rr1),
    .rsp_out0(l_ro0), .rsp_out1(l_ro1), .rsp_cond0(l_rc0), .rsp_cond1(l_rc1),
    .alu_reg0(l_ar0), .alu_reg1(l_ar1), .alu_op(l_aop),
    .alu_out(l_aout), .alu_cond(l_acond), .busy(l_busy)
  );

  function automatic logic [15:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                        input logic [3:0] op, input logic [15:0] prev);
    case (op)
      4'h0: alu_f = a & b;
      4'h1: alu_f = a | b;
      4'h2: alu_f = a ^ b;
      4'h3: alu_f = ~a;
      4'h4: alu_f = a << 1;
      4'h5: alu_f = a >> 1;
      4'h6: alu_f = a + b;
      4'h7: alu_f = a - b;
      4'h8: alu_f = a;
      4'h9: alu_f = b;
      4'ha: alu_f = a + 16'd1;
      default: alu_f = prev;
    endcase
  endfunction

  function automatic logic [4:0] cond_f(input logic [15:0] a, input logic [15:0] b);
    cond_f = {$signed(a) > $signed(b), $signed(a) < $signed(b), a > b, a < b, a == b};
  endfunction

  // Single-stage ALU; idle opcode leaves outputs untouched.
  always @(posedge clk) begin
    if (aop != 4'hf) begin
      aout  <= alu_f(ar0, ar1, aop, aout);
      acond <= cond_f(ar0, ar1);
    end
  end

  // Three-stage ALU for the latency-3 instance.
  logic [15:0] s0o, s1o;
  logic [4:0]  s0c, s1c;
  always @(posedge clk) begin
    if (l_aop != 4'hf) begin
      s0o <= alu_f(l_ar0, l_ar1, l_aop, s0o);
      s0c <= cond_f(l_ar0, l_ar1);
    end
    s1o     <= s0o;
    s1c     <= s0c;
    l_aout  <= s1o;
    l_acond <= s1c;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    v0 = 1'b1; v1 = 1'b0; rr0 = 1'b0; rr1 = 1'b0;
    a0 = '0; a1 = '0; b0 = '0; b1 = '0; op0 = '0; op1 = '0;
    l_v0 = 1'b0; l_v1 = 1'b0; l_rr0 = 1'b1; l_rr1 = 1'b1;
    l_a0 = 16'h0005; l_b0 = 16'h0003; l_op0 = 4'h7;
    l_a1 = 16'h0007; l_b1 = 16'h0009; l_op1 = 4'h6;
    tick(); #1;
    check("rst_ready0", rdy0, 0);
    check("rst_busy", busy, 0);
    check("rst_rv0", rv0, 0);
    check("rst_out0", ro0, 0);
    check("rst_cond0", rc0, 0);
    check("rst_aop", aop, 4'hf);
    v0 = 1'b0;
    tick();
    rst = 1'b0;

    // single op: 3 + 5
    tick();
    v0 = 1'b1; a0 = 16'h0003; b0 = 16'h0005; op0 = 4'h6; rr0 = 1'b1;
    #1;
    check("t1_ready0", rdy0, 1);
    check("t1_ready1", rdy1, 0);
    check("t1_reg0", ar0, 16'h0003);
    check("t1_reg1", ar1, 16'h0005);
    check("t1_op", aop, 4'h6);
    tick(); v0 = 1'b0; #1;
    check("t1_rv0_n1", rv0, 0);
    check("t1_busy_n1", busy, 1);
    check("idle_op", aop, 4'hf);
    check("idle_reg0", ar0, 16'h0003);
    check("idle_reg1", ar1, 16'h0005);
    tick(); #1;
    check("t1_rv0_n2", rv0, 1);
    check("t1_out0", ro0, 16'h0008);
    check("t1_cond0", rc0, 5'b01010);
    tick(); #1;
    check("t1_rv0_pop", rv0, 0);
    check("t1_busy_pop", busy, 0);
    check("t1_out0_hold", ro0, 16'h0008);

    // tie with port 0 granted last: port 1 wins
    v0 = 1'b1; v1 = 1'b1; a1 = 16'h0001; b1 = 16'h0001; op1 = 4'h6; rr1 = 1'b1;
    #1;
    check("tie_ready1", rdy1, 1);
    check("tie_ready0", rdy0, 0);
    tick(); v0 = 1'b0; v1 = 1'b0;
    tick(); tick(); tick(); #1;
    check("tie_drain_busy", busy, 0);

    // round robin after reset
    rst = 1'b1; tick(); rst = 1'b0;
    v0 = 1'b1; v1 = 1'b1; rr0 = 1'b1; rr1 = 1'b1;
    a0 = 16'h0001; b0 = 16'h0002; op0 = 4'h7;
    a1 = 16'hffff; b1 = 16'h0001; op1 = 4'h7;
    #1;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("rr_ready0_c%0d", i), rdy0, (i % 3) == 0);
      check($sformatf("rr_ready1_c%0d", i), rdy1, (i % 3) == 1);
      check($sformatf("rr_rv0_c%0d", i), rv0, (i % 3) == 2);
      check($sformatf("rr_rv1_c%0d", i), rv1, (i % 3) == 0 && i > 0);
      if ((i % 3) == 2) begin
        check("rr_out0", ro0, 16'hffff);
        check("rr_cond0", rc0, 5'b01010);
      end
      if ((i % 3) == 0 && i > 0) begin
        check("rr_out1", ro1, 16'hfffe);
        check("rr_cond1", rc1, 5'b01100);
      end
      tick(); #1;
    end
    v0 = 1'b0; v1 = 1'b0;
    tick(); tick(); tick(); #1;
    check("rr_drain_busy", busy, 0);

    // backpressure on port 1
    v0 = 1'b1; v1 = 1'b1; rr1 = 1'b0;
    a1 = 16'h0010; b1 = 16'h0003; op1 = 4'h6;
    #1;
    for (int i = 0; i < 9; i++) begin
      check($sformatf("bp_ready0_c%0d", i), rdy0, (i % 3) == 0);
      check($sformatf("bp_ready1_c%0d", i), rdy1, i == 1);
      if (i >= 3) begin
        check($sformatf("bp_rv1_c%0d", i), rv1, 1);
        check($sformatf("bp_out1_c%0d", i), ro1, 16'h0013);
        check($sformatf("bp_cond1_c%0d", i), rc1, 5'b10100);
      end
      if (i == 8) rr1 = 1'b1;
      tick(); #1;
    end
    check("bp_release_ready1", rdy1, 1);
    check("bp_release_ready0", rdy0, 0);
    tick(); v0 = 1'b0; v1 = 1'b0;
    tick(); tick(); tick(); #1;
    check("bp_drain_busy", busy, 0);

    // reset mid-flight
    v0 = 1'b1; a0 = 16'h0003; b0 = 16'h0005; op0 = 4'h6; rr0 = 1'b1;
    #1;
    check("rmf_ready0", rdy0, 1);
    tick(); v0 = 1'b0; rst = 1'b1; #1;
    check("rmf_busy", busy, 0);
    check("rmf_rv0_a", rv0, 0);
    tick(); #1;
    check("rmf_rv0_b", rv0, 0);
    rst = 1'b0;
    tick(); #1;
    check("rmf_rv0_c", rv0, 0);
    tick(); #1;
    check("rmf_rv0_d", rv0, 0);
    check("rmf_busy_d", busy, 0);
    v0 = 1'b1; a0 = 16'h0100; b0 = 16'h0100; op0 = 4'h6;
    #1;
    check("rmf_new_ready0", rdy0, 1);
    tick(); v0 = 1'b0;
    tick(); #1;
    check("rmf_new_rv0", rv0, 1);
    check("rmf_new_out0", ro0, 16'h0200);
    check("rmf_new_cond0", rc0, 5'b00001);

    // latency 3 with interleaved issue
    l_v0 = 1'b1; l_v1 = 1'b1;
    #1;
    check("l3_ready0_c0", l_rdy0, 1);
    check("l3_ready1_c0", l_rdy1, 0);
    tick(); #1;
    check("l3_ready1_c1", l_rdy1, 1);
    check("l3_ready0_c1", l_rdy0, 0);
    tick(); l_v0 = 1'b0; l_v1 = 1'b0; #1;
    check("l3_rv0_c2", l_rv0, 0);
    tick(); #1;
    check("l3_rv0_c3", l_rv0, 0);
    tick(); #1;
    check("l3_rv0_c4", l_rv0, 1);
    check("l3_out0", l_ro0, 16'h0002);
    check("l3_cond0", l_rc0, 5'b10100);
    check("l3_rv1_c4", l_rv1, 0);
    tick(); #1;
    check("l3_rv1_c5", l_rv1, 1);
    check("l3_out1", l_ro1, 16'h0010);
    check("l3_cond1", l_rc1, 5'b01010);
    check("l3_rv0_c5", l_rv0, 0);
    tick(); #1;
    check("l3_busy_c6", l_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
